// File: rtl/fp_div_pkg.sv
// Shared constants, types and the result classifier for the divider result queue.
package fp_div_pkg;

  // IEEE-754 single-precision field layout
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned FRAC_LSB = 0;
  localparam int unsigned EXP_LSB  = FRAC_W;
  localparam int unsigned FP_W     = 32;

  // Classification flag bit positions
  localparam int unsigned FLAG_W     = 4;
  localparam int unsigned FLG_ZERO   = 0;
  localparam int unsigned FLG_INF    = 1;
  localparam int unsigned FLG_NAN    = 2;
  localparam int unsigned FLG_DENORM = 3;

  // Default tag width
  localparam int unsigned TAG_W = 4;

  // Buffered result entry at the default tag width. The queue packs the same fields in
  // the same order (z high, flags low) so that MASK_W can be overridden.
  typedef struct packed {
    logic [FP_W-1:0]   z;
    logic [TAG_W-1:0]  mask;
    logic [FLAG_W-1:0] flags;
  } result_t;

  // The sign bit is ignored. At most one flag is set; normal numbers get no flag.
  function automatic logic [FLAG_W-1:0] classify(input logic [FP_W-1:0] z);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic [FLAG_W-1:0] flg;
    e   = z[EXP_LSB +: EXP_W];
    f   = z[FRAC_LSB +: FRAC_W];
    flg = '0;
    if (e == '0) begin
      if (f == '0) flg[FLG_ZERO] = 1'b1;
      else         flg[FLG_DENORM] = 1'b1;
    end else if (e == '1) begin
      if (f == '0) flg[FLG_INF] = 1'b1;
      else         flg[FLG_NAN] = 1'b1;
    end
    return flg;
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// A push while full is dropped unless a pop happens on the same edge.
module fp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty,
  output logic [AW:0]      oCount
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign oEmpty = (wrPtr == rdPtr);
  assign oFull  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign oCount = wrPtr - rdPtr;
  assign doPop  = iPop & ~oEmpty;
  assign doPush = iPush & (~oFull | doPop);
  // An empty FIFO presents zero rather than stale storage
  assign oData  = oEmpty ? '0 : mem[rdPtr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= iData;
  end

endmodule

// File: rtl/fp_div_result_queue.sv
// Pairs divider results with their issue tags, classifies them and buffers them behind a
// valid/ready port. Issue credit covers both in-flight and buffered entries, so the
// divider (which cannot stall) never overruns the result buffer.
module fp_div_result_queue
  import fp_div_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MASK_W = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iIssueValid,
  input  logic [MASK_W-1:0] iIssueMask,
  output logic              oIssueReady,
  input  logic              iDivDone,
  input  logic [31:0]       iDivZ,
  output logic              oValid,
  input  logic              iReady,
  output logic [31:0]       oZ,
  output logic [MASK_W-1:0] oMask,
  output logic [3:0]        oFlags,
  output logic [CNT_W-1:0]  oOutstanding,
  output logic              oOverflow,
  output logic              oUnderflow
);

  localparam int unsigned RES_W = FP_W + MASK_W + FLAG_W;
  localparam logic [CNT_W:0] DepthC = (CNT_W + 1)'(DEPTH);

  logic [1:0]        rstSyncQ;
  logic              rstInt;

  logic              tagPush;
  logic              tagPop;
  logic [MASK_W-1:0] tagHead;
  logic              tagFull;
  logic              tagEmpty;
  logic [CNT_W-1:0]  tagCount;

  logic              resPush;
  logic              resPop;
  logic [RES_W-1:0]  resIn;
  logic [RES_W-1:0]  resOut;
  logic              resFull;
  logic              resEmpty;
  logic [CNT_W-1:0]  resCount;

  logic [CNT_W:0]    occ;
  logic              doneOk;

  // Reset asserts immediately, releases two edges later in step with the clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rstSyncQ <= 2'b11;
    else       rstSyncQ <= {rstSyncQ[0], 1'b0};
  end
  assign rstInt = rstSyncQ[1];

  // Credit: everything issued and not yet consumed counts against DEPTH
  assign occ         = {1'b0, tagCount} + {1'b0, resCount};
  assign oIssueReady = (occ < DepthC);

  // A completion with no tag waiting is an underflow and is discarded
  assign doneOk  = iDivDone & ~tagEmpty;
  assign tagPop  = doneOk;
  assign tagPush = iIssueValid & (~tagFull | tagPop);
  assign resPop  = ~resEmpty & iReady;
  assign resPush = doneOk & (~resFull | resPop);
  assign resIn   = {iDivZ, tagHead, classify(iDivZ)};

  fp_sync_fifo #(
    .WIDTH (MASK_W),
    .DEPTH (DEPTH)
  ) tagFifo (
    .clk    (clk),
    .reset  (rstInt),
    .iPush  (tagPush),
    .iData  (iIssueMask),
    .iPop   (tagPop),
    .oData  (tagHead),
    .oFull  (tagFull),
    .oEmpty (tagEmpty),
    .oCount (tagCount)
  );

  fp_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) resFifo (
    .clk    (clk),
    .reset  (rstInt),
    .iPush  (resPush),
    .iData  (resIn),
    .iPop   (resPop),
    .oData  (resOut),
    .oFull  (resFull),
    .oEmpty (resEmpty),
    .oCount (resCount)
  );

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge rstInt) begin
    if (rstInt) begin
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      if (iIssueValid && !oIssueReady) oOverflow  <= 1'b1;
      if (iDivDone && tagEmpty)        oUnderflow <= 1'b1;
    end
  end

  assign oValid       = ~resEmpty;
  assign oZ           = resOut[RES_W-1 -: FP_W];
  assign oMask        = resOut[FLAG_W +: MASK_W];
  assign oFlags       = resOut[FLAG_W-1:0];
  assign oOutstanding = tagCount;

endmodule
